// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path: bus addresses, status bit
// positions, ingress FSM states and the status-word packing helper.
package uart_rx_fifo_pkg;

  localparam logic [15:0] UART_ADDR    = 16'h1000;
  localparam logic [15:0] MISC_IN_ADDR = 16'h2000;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_UNDERFLOW = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } rx_state_e;

  // Status word: {count[7:0], 5'b0, underflow, full, not_empty}.
  function automatic logic [15:0] pack_status(input logic [7:0] count,
                                              input logic       underflow,
                                              input logic       full,
                                              input logic       not_empty);
    logic [15:0] s;
    s                 = '0;
    s[ST_COUNT_LSB+:8] = count;
    s[ST_UNDERFLOW]   = underflow;
    s[ST_FULL]        = full;
    s[ST_NOT_EMPTY]   = not_empty;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO. Push and pop are
// self-guarded against full/empty; head is the entry at the read pointer.
module uart_rx_fifo_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned   Depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CountFull = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign do_push = push && (count_q != CountFull);
  assign do_pop  = pop && (count_q != '0);
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  // Occupancy follows net pushes minus pops; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  // Pointer and count registers; pointers wrap naturally at Depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains bytes out of buart into a FIFO, presents the
// head byte and a status word to the CPU, and tracks a sticky underflow flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_valid,
  input  logic [DATA_W-1:0] uart_data,
  output logic              uart_rd,
  input  logic              cpu_rd,
  input  logic              cpu_clr,
  output logic [15:0]       cpu_dout,
  output logic [15:0]       status
);

  localparam logic [ADDR_W:0] CountFull = {1'b1, {ADDR_W{1'b0}}};

  rx_state_e         state_q, state_d;
  logic              uart_rd_q, uart_rd_d;
  logic              underflow_q, underflow_d;
  logic              push;
  logic [DATA_W-1:0] head;
  logic [ADDR_W:0]   count;
  logic              not_empty, full;

  assign not_empty = (count != '0);
  assign full      = (count == CountFull);

  uart_rx_fifo_sync_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(uart_data),
    .pop  (cpu_rd),
    .head (head),
    .count(count)
  );

  // Ingress FSM: one push per buart byte, then wait for valid to drop.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    uart_rd_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Full uses the registered count, so a same-cycle pop does not admit a push.
        if (uart_valid && !full) begin
          push      = 1'b1;
          uart_rd_d = 1'b1;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (!uart_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky underflow: a new underflow beats a same-cycle clear.
  always_comb begin
    underflow_d = underflow_q;
    if (cpu_rd && !not_empty) begin
      underflow_d = 1'b1;
    end else if (cpu_clr) begin
      underflow_d = 1'b0;
    end
  end

  // State, pop strobe and flag registers; reset kills any in-flight uart_rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      uart_rd_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      uart_rd_q   <= uart_rd_d;
      underflow_q <= underflow_d;
    end
  end

  assign uart_rd  = uart_rd_q;
  assign cpu_dout = not_empty ? {{(16 - DATA_W){1'b0}}, head} : 16'h0000;
  assign status   = pack_status(8'(count), underflow_q, full, not_empty);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model, a
// per-cycle compare process, a small buart emulator and directed scenarios.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset, uart_valid, cpu_rd, cpu_clr;
  logic [7:0]  uart_data;
  logic        uart_rd;
  logic [15:0] cpu_dout, status;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .ADDR_W(4),
    .DATA_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_valid(uart_valid),
    .uart_data (uart_data),
    .uart_rd   (uart_rd),
    .cpu_rd    (cpu_rd),
    .cpu_clr   (cpu_clr),
    .cpu_dout  (cpu_dout),
    .status    (status)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  byte unsigned mq[$];
  bit           m_uf, m_wait, m_rd;

  // Bench-side buart emulator and capture
  byte unsigned src[$];
  byte unsigned sent[$];
  byte unsigned got[$];
  bit           auto_src = 1'b0;
  bit           chk_en   = 1'b0;
  int           rd_pulses;

  function automatic logic [15:0] exp_dout();
    if (mq.size() > 0) return {8'h00, mq[0]};
    return 16'h0000;
  endfunction

  function automatic logic [15:0] exp_status();
    logic [7:0] c;
    c = 8'(mq.size());
    return {c, 5'b0, m_uf, (mq.size() == 16), (mq.size() != 0)};
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit do_push, new_uf;
    if (reset) begin
      mq.delete();
      m_uf   = 1'b0;
      m_wait = 1'b0;
      m_rd   = 1'b0;
    end else begin
      do_push = !m_wait && uart_valid && (mq.size() < 16);
      new_uf  = cpu_rd && (mq.size() == 0);
      if (cpu_rd && mq.size() > 0) void'(mq.pop_front());
      if (new_uf) m_uf = 1'b1;
      else if (cpu_clr) m_uf = 1'b0;
      if (do_push) mq.push_back(uart_data);
      m_rd = do_push;
      if (do_push) m_wait = 1'b1;
      else if (!uart_valid) m_wait = 1'b0;
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check16("cpu_dout", cpu_dout, exp_dout());
      check16("status", status, exp_status());
      check16("uart_rd", {15'b0, uart_rd}, {15'b0, m_rd});
      if (uart_rd) rd_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    // buart: rd consumes the byte and drops valid; next byte follows a cycle later
    if (auto_src) begin
      if (uart_rd) begin
        if (src.size() > 0) void'(src.pop_front());
        uart_valid = 1'b0;
      end else if (!uart_valid && src.size() > 0) begin
        uart_valid = 1'b1;
        uart_data  = src[0];
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_pop();
    cpu_rd = 1'b1;
    got.push_back(cpu_dout[7:0]);
    tick();
    cpu_rd = 1'b0;
  endtask

  bit seen;

  initial begin
    reset      = 1'b1;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    cpu_rd     = 1'b0;
    cpu_clr    = 1'b0;
    rd_pulses  = 0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check16("rst_dout", cpu_dout, 16'h0000);
    check16("rst_status", status, 16'h0000);
    check16("rst_uart_rd", {15'b0, uart_rd}, 16'h0000);

    // 1: single byte
    auto_src  = 1'b1;
    rd_pulses = 0;
    seen      = 1'b0;
    src.push_back(8'hA5);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (uart_rd && !seen) begin
        seen = 1'b1;
        check16("t1_dout", cpu_dout, 16'h00A5);
        check16("t1_status", status, 16'h0101);
      end
    end
    check16("t1_seen", {15'b0, seen}, 16'h0001);
    check16("t1_pulses", 16'(rd_pulses), 16'd1);
    cpu_pop();
    check16("t1_pop_status", status, 16'h0000);

    // 2: fill to full, 17th byte back-pressured
    rd_pulses = 0;
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    src.push_back(8'h10);
    cycles(70);
    check16("t2_full_status", status, 16'h1003);
    check16("t2_pulses16", 16'(rd_pulses), 16'd16);
    check16("t2_held_valid", {15'b0, uart_valid}, 16'h0001);
    check16("t2_head", cpu_dout, 16'h0000);
    got.delete();
    cpu_pop();
    check16("t2_after_pop", status, 16'h0F01);
    cycles(4);
    check16("t2_refill", status, 16'h1003);
    check16("t2_pulses17", 16'(rd_pulses), 16'd17);
    for (int i = 0; i < 16; i++) cpu_pop();
    check16("t2_got_n", 16'(got.size()), 16'd17);
    for (int i = 0; i < 17 && i < got.size(); i++) check16("t2_order", 16'(got[i]), 16'(i));

    // 3: underflow and clear, set beats clear
    cpu_rd = 1'b1;
    check16("t3_dout", cpu_dout, 16'h0000);
    tick();
    cpu_rd = 1'b0;
    check16("t3_uf", status, 16'h0004);
    cpu_clr = 1'b1;
    tick();
    cpu_clr = 1'b0;
    check16("t3_clr", status, 16'h0000);
    cpu_rd  = 1'b1;
    cpu_clr = 1'b1;
    tick();
    cpu_rd  = 1'b0;
    cpu_clr = 1'b0;
    check16("t3_set_wins", status, 16'h0004);
    cpu_clr = 1'b1;
    tick();
    cpu_clr = 1'b0;

    // 4: simultaneous push and pop at count 3
    src.push_back(8'h31);
    src.push_back(8'h32);
    src.push_back(8'h33);
    cycles(12);
    check16("t4_pre", status, 16'h0301);
    auto_src   = 1'b0;
    uart_valid = 1'b1;
    uart_data  = 8'h34;
    got.delete();
    cpu_pop();
    uart_valid = 1'b0;
    check16("t4_pop_val", 16'(got[0]), 16'h0031);
    check16("t4_count", status, 16'h0301);
    tick();
    got.delete();
    for (int i = 0; i < 3; i++) cpu_pop();
    check16("t4_d0", 16'(got[0]), 16'h0032);
    check16("t4_d1", 16'(got[1]), 16'h0033);
    check16("t4_d2", 16'(got[2]), 16'h0034);

    // 5: reset while in ACK with 5 bytes stored
    auto_src = 1'b1;
    for (int i = 0; i < 4; i++) src.push_back(8'(8'h51 + i));
    cycles(16);
    auto_src   = 1'b0;
    uart_valid = 1'b1;
    uart_data  = 8'h55;
    tick();
    check16("t5_pre", status, 16'h0501);
    check16("t5_rd_high", {15'b0, uart_rd}, 16'h0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check16("t5_rst_status", status, 16'h0000);
    check16("t5_rst_rd", {15'b0, uart_rd}, 16'h0000);
    tick();
    check16("t5_refetch_status", status, 16'h0101);
    check16("t5_refetch_dout", cpu_dout, 16'h0055);
    uart_valid = 1'b0;
    tick();
    cpu_pop();

    // 6: 40 bytes with interleaved reads, pointers wrap twice
    sent.delete();
    got.delete();
    for (int i = 0; i < 40; i++) begin
      src.push_back(8'(i * 7 + 3));
      sent.push_back(8'(i * 7 + 3));
    end
    auto_src = 1'b1;
    for (int cyc = 0; cyc < 2000 && got.size() < 40; cyc++) begin
      if ((cyc % 4) == 0 && mq.size() > 0) cpu_pop();
      else tick();
    end
    check16("t6_count", 16'(got.size()), 16'd40);
    for (int i = 0; i < 40 && i < got.size(); i++) check16("t6_order", 16'(got[i]), 16'(sent[i]));
    check16("t6_empty", status, 16'h0000);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
